// File: rtl/systolic_array_param.sv
// Output-stationary NxN systolic matrix multiplier with a runtime-selectable active size.
// A rows enter from the west and B columns from the north, skewed so that element k meets in PE(i,j) at k+i+j+1.
module systolic_array_param #(
    parameter int N  = 3,
    parameter int DW = 2,
    parameter int AW = 2*DW + $clog2(N) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [$clog2(N+1)-1:0] size,
    input  logic                  in_valid,
    input  logic [N*DW-1:0]       a_vec,
    input  logic [N*DW-1:0]       b_vec,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [N*N*AW-1:0]     c_flat
);

    localparam int SW = $clog2(N+1);
    localparam int CW = $clog2(2*N);

    // Handshake: a vector moves on every rising edge where in_valid && in_ready;
    // in_ready depends only on the FSM state, never on in_valid.
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t        state, state_d;
    logic [SW-1:0] s_q;
    logic [SW-1:0] k_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] drain_last;
    logic          done_d, err_d;
    logic          size_ok, start_ok, accept, last_vec;

    assign size_ok    = (size != '0) && (size <= SW'(N));
    assign start_ok   = (state == IDLE) && start && size_ok;
    assign accept     = in_valid && (state == LOAD);
    assign last_vec   = accept && (k_q == s_q - SW'(1));
    // The final product reaches PE(s-1,s-1) 2s-1 edges after the last vector is taken.
    assign drain_last = CW'({s_q, 1'b0}) - CW'(2);

    assign in_ready = (state == LOAD);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            s_q   <= '0;
            k_q   <= '0;
            cnt_q <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_d;
            done  <= done_d;
            err   <= err_d;
            if (start_ok) begin
                s_q <= size;
                k_q <= '0;
            end else if (accept) begin
                k_q <= k_q + SW'(1);
            end
            if (state != DRAIN) cnt_q <= '0;
            else                cnt_q <= cnt_q + CW'(1);
        end
    end

    always_comb begin
        state_d = state;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (size_ok) state_d = LOAD;
                    else         err_d   = 1'b1;
                end
            end
            LOAD: begin
                if (last_vec) state_d = DRAIN;
            end
            DRAIN: begin
                if (cnt_q == drain_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [DW-1:0] a_west    [N];
    logic          a_west_v  [N];
    logic [DW-1:0] b_north   [N];
    logic          b_north_v [N];
    logic [DW-1:0] a_east    [N][N-1];
    logic          a_east_v  [N][N-1];
    logic [DW-1:0] b_south   [N-1][N];
    logic          b_south_v [N-1][N];
    logic [AW-1:0] acc_w     [N][N];

    // Lane i carries i+1 registers: one capture stage plus i stages of skew.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] a_sr  [0:i];
        logic          a_sr_v[0:i];
        logic [DW-1:0] b_sr  [0:i];
        logic          b_sr_v[0:i];
        logic          lane_on;

        assign lane_on = SW'(i) < s_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int m = 0; m <= i; m++) begin
                    a_sr[m]   <= '0;
                    a_sr_v[m] <= 1'b0;
                    b_sr[m]   <= '0;
                    b_sr_v[m] <= 1'b0;
                end
            end else begin
                a_sr[0]   <= a_vec[i*DW +: DW];
                a_sr_v[0] <= accept && lane_on;
                b_sr[0]   <= b_vec[i*DW +: DW];
                b_sr_v[0] <= accept && lane_on;
                for (int m = 1; m <= i; m++) begin
                    a_sr[m]   <= a_sr[m-1];
                    a_sr_v[m] <= a_sr_v[m-1];
                    b_sr[m]   <= b_sr[m-1];
                    b_sr_v[m] <= b_sr_v[m-1];
                end
            end
        end

        assign a_west[i]    = a_sr[i];
        assign a_west_v[i]  = a_sr_v[i];
        assign b_north[i]   = b_sr[i];
        assign b_north_v[i] = b_sr_v[i];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DW-1:0]   a_in, b_in;
            logic            a_in_v, b_in_v, pe_on;
            logic [2*DW-1:0] prod;
            logic [AW-1:0]   acc;

            if (j == 0) begin : g_wedge
                assign a_in   = a_west[i];
                assign a_in_v = a_west_v[i];
            end else begin : g_winner
                assign a_in   = a_east[i][j-1];
                assign a_in_v = a_east_v[i][j-1];
            end

            if (i == 0) begin : g_nedge
                assign b_in   = b_north[j];
                assign b_in_v = b_north_v[j];
            end else begin : g_ninner
                assign b_in   = b_south[i-1][j];
                assign b_in_v = b_south_v[i-1][j];
            end

            assign pe_on = (SW'(i) < s_q) && (SW'(j) < s_q);
            assign prod  = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, b_in};

            always_ff @(posedge clk or posedge rst) begin
                if (rst)                              acc <= '0;
                else if (start_ok)                    acc <= '0;
                else if (a_in_v && b_in_v && pe_on)   acc <= acc + AW'(prod);
            end

            assign acc_w[i][j] = acc;

            // The last column and row have no neighbour, so nothing is forwarded past them.
            if (j < N-1) begin : g_fwd_e
                logic [DW-1:0] a_q;
                logic          a_q_v;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_q   <= '0;
                        a_q_v <= 1'b0;
                    end else begin
                        a_q   <= a_in;
                        a_q_v <= a_in_v;
                    end
                end
                assign a_east[i][j]   = a_q;
                assign a_east_v[i][j] = a_q_v;
            end

            if (i < N-1) begin : g_fwd_s
                logic [DW-1:0] b_q;
                logic          b_q_v;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        b_q   <= '0;
                        b_q_v <= 1'b0;
                    end else begin
                        b_q   <= b_in;
                        b_q_v <= b_in_v;
                    end
                end
                assign b_south[i][j]   = b_q;
                assign b_south_v[i][j] = b_q_v;
            end
        end
    end

    always_comb begin
        c_flat = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                c_flat[(i*N+j)*AW +: AW] = acc_w[i][j];
            end
        end
    end

endmodule
